coherent_avg_multich: RTL and testbench
=======================================

# coherent_avg_multich

Parametrised multi-channel coherent (synchronous) averager for the lock-in processing chain. It sits between the ADC/decimation stream and the demodulator. Per channel it accumulates N sync-aligned frames of M samples into on-chip memory, and emits the normalised average during the last frame of each block. Compared with the single-channel averager it adds:
- channel count and width parameters
- full-precision accumulators with programmable right-shift and saturation
- a memory-clear state machine
- error/status flags

## Interface
- DATA_W, 32, sample width per channel (signed, two's complement)
- CH, 2, number of channels, processed in lockstep on one stream beat
- ADDR_W, 12, bin address width; DEPTH = 2^ADDR_W bins per channel
- ACC_W, DATA_W+16, accumulator width per bin; cannot overflow for N ≤ 65535
- clk  in  1  clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run; low forces CLEAR then IDLE
- ptos_x_ciclo  in  16  M, samples per frame; latched at block start
- frames_prom_coherente  in  16  N, frames per block; 0 treated as 1; latched at block start
- shift  in  6  arithmetic right shift applied to output sum; latched at block start
- sync  in  1  frame-start marker, qualified by data_in_valid
- bypass  in  1  combinational pass-through of data/valid/sync
- data_in_valid  in  1  input beat valid
- data_in  in  CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- data_out_valid  out  1  output beat valid
- data_out  out  CH*DATA_W  normalised averages, same packing as data_in
- sync_out  out  1  high with bin 0 of each output frame
- busy  out  1  high while in CLEAR
- len_err  out  1  sticky; a sample was dropped for index ≥ M or ≥ DEPTH
- sat_err  out  1  sticky; an output value was saturated
- cfg_err  out  1  sticky; block start with M < 3 or M > DEPTH

## Operation
- FSM states: CLEAR, IDLE, WAIT_SYNC, ACCUM.
- **CLEAR** (entered on reset or on enable falling)
  - Writes 0 to all DEPTH bins of every channel, one address per cycle.
  - Then goes to WAIT_SYNC if enable = 1, else IDLE.
  - Input beats are ignored.
- **IDLE → WAIT_SYNC** on enable = 1.
- **WAIT_SYNC → ACCUM** on a valid beat with sync = 1:
  - latch M, N, shift;
  - frame k = 1, index = 0;
  - the sync beat itself is sample 0.
- If cfg_err condition holds at that beat: set cfg_err and stay in WAIT_SYNC.
- **ACCUM**, per valid beat at index i:
  - If i < M and i < DEPTH: bin[i] ← (k == 1 ? x : bin[i] + x), with x sign-extended to ACC_W.
  - Otherwise drop the sample and set len_err.
  - index increments per valid beat.
- **Frame boundaries**
  - A valid beat with sync = 1 resets index to 0 and increments k.
  - After frame N, the next sync starts a new block: k = 1, config relatched.
  - Bins not reached in a short frame keep their previous content.
- **Output during frame k == N**
  - Each accumulated sum s is emitted as sat(s >>> shift) to the DATA_W range.
  - Saturation goes to +2^(DATA_W-1)-1 or -2^(DATA_W-1), and sets sat_err.
- **Errors:** len_err, sat_err and cfg_err clear only on reset.
- **bypass = 1:** data_out = data_in, data_out_valid = data_in_valid, sync_out = sync, combinationally. The internal FSM keeps running.
- **enable low mid-block:** the block is abandoned; in-flight pipeline beats are discarded (no output valid); FSM enters CLEAR.

## Timing
- Reset values: data_out = 0, data_out_valid = 0, sync_out = 0, len_err = sat_err = cfg_err = 0, busy = 1 (FSM = CLEAR).
- Pipeline advances every cycle regardless of valid:
  - E0: input registered.
  - E1: read address presented to synchronous RAM.
  - E2: read data plus x computed into sum.
  - E3: bin written and output registers loaded.
- Latency from the input beat edge to data_out_valid is 3 clk; throughput is 1 beat/cycle.
- No read/write hazard: the same bin recurs at least M ≥ 3 beats later.
- CLEAR lasts exactly DEPTH cycles; busy falls the cycle CLEAR exits.
- sync_out is high for exactly the one output beat of bin 0 in frame N.
- data_out holds its value between valid beats.

## Test plan
- **Basic average:** CH = 2, M = 4, N = 4, shift = 2. Ch0 = 8 and ch1 = −4 constant over 4 frames → during frame 4, four beats of 8 / −4; sync_out on the first; latency 3 clk.
- **Ramp coherence:** M = 8, N = 16, shift = 4. Input = bin index. Valid gapped randomly (50%) → output bins 0..7 exactly; no errors.
- **Saturation:** DATA_W = 16, N = 4, shift = 0, input 30000 → outputs 32767 and sat_err = 1. Input −30000 → −32768.
- **Overlong frame:** M = 4, six beats between syncs → beats 4 and 5 dropped; len_err = 1; averages of bins 0..3 correct.
- **Reset/enable mid-block:** deassert enable in frame 2 → no data_out_valid; busy high for DEPTH cycles. Re-run gives a correct average with no stale data. Async reset asserted mid-beat → outputs zero immediately.
- **Config guard and bypass:** M = 2 at sync → cfg_err = 1 and no output. bypass = 1 → data_out equals data_in in the same cycle.

Source files
------------

// File: rtl/coherent_avg_multich.sv
// Multi-channel coherent averager: accumulates N sync-aligned frames of M
// samples per channel in on-chip RAM and emits sat(sum >>> shift) in frame N.
module coherent_avg_multich #(
  parameter int DATA_W = 32,
  parameter int CH     = 2,
  parameter int ADDR_W = 12,
  parameter int ACC_W  = DATA_W + 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [15:0]          ptos_x_ciclo,
  input  logic [15:0]          frames_prom_coherente,
  input  logic [5:0]           shift,
  input  logic                 sync,
  input  logic                 bypass,
  input  logic                 data_in_valid,
  input  logic [CH*DATA_W-1:0] data_in,
  output logic                 data_out_valid,
  output logic [CH*DATA_W-1:0] data_out,
  output logic                 sync_out,
  output logic                 busy,
  output logic                 len_err,
  output logic                 sat_err,
  output logic                 cfg_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT_SYNC, ACCUM} state_t;

  typedef struct packed {
    logic              first;
    logic              last;
    logic              zero;
    logic [5:0]        sh;
    logic [ADDR_W-1:0] addr;
  } ctl_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [15:0]       m_r, n_r, k, idx;
  logic [5:0]        sh_r;
  logic [15:0]       n_in, bidx;
  logic              cfg_bad, start, adv, plain, go, inrange, kill;
  ctl_t              c0, s1_c, s2_c, s3_c;
  logic              s1_v, s2_v, s3_v;
  logic [CH*DATA_W-1:0] s1_x, s2_x, satv, dout_r;
  logic [CH*ACC_W-1:0]  ram_q, acc, sum, wd;
  logic [CH-1:0]        sat;
  logic              dv_r, so_r, we;
  logic [ADDR_W-1:0] wa;

  logic [CH*ACC_W-1:0] mem [DEPTH];

  always_comb begin
    n_in = (frames_prom_coherente == 16'd0) ? 16'd1 : frames_prom_coherente;
    cfg_bad = (ptos_x_ciclo < 16'd3) ||
              ({16'd0, ptos_x_ciclo} > 32'(DEPTH));
    start = 1'b0;
    adv   = 1'b0;
    plain = 1'b0;
    if (data_in_valid && enable &&
        (state == WAIT_SYNC || state == ACCUM)) begin
      if (sync) begin
        if (state == WAIT_SYNC || k == n_r) start = 1'b1;
        else adv = 1'b1;
      end else if (state == ACCUM) begin
        plain = 1'b1;
      end
    end
    go = (start && !cfg_bad) || adv || plain;
    bidx = plain ? idx : 16'd0;
    inrange = !plain ||
              ((idx < m_r) && ({16'd0, idx} < 32'(DEPTH)));
    kill = !enable || state == CLEAR;
    c0.first = start || (plain && k == 16'd1);
    c0.last  = start ? (n_in == 16'd1) :
               adv   ? (k + 16'd1 == n_r) : (k == n_r);
    c0.zero  = start || adv;
    c0.sh    = start ? shift : sh_r;
    c0.addr  = bidx[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      m_r      <= 16'd3;
      n_r      <= 16'd1;
      sh_r     <= '0;
      k        <= 16'd1;
      idx      <= '0;
      len_err  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      unique case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == ADDR_W'(DEPTH - 1))
            state <= enable ? WAIT_SYNC : IDLE;
        end
        IDLE: if (enable) state <= WAIT_SYNC;
        WAIT_SYNC, ACCUM: begin
          if (!enable) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end else if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
              state   <= WAIT_SYNC;
            end else begin
              m_r   <= ptos_x_ciclo;
              n_r   <= n_in;
              sh_r  <= shift;
              k     <= 16'd1;
              idx   <= 16'd1;
              state <= ACCUM;
            end
          end else if (adv) begin
            k   <= k + 16'd1;
            idx <= 16'd1;
          end else if (plain) begin
            idx <= (idx == 16'hFFFF) ? idx : idx + 16'd1;
            if (!inrange) len_err <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [ACC_W-1:0] xs, acc_c, shd;
    logic hi, lo;
    assign xs    = ACC_W'($signed(s2_x[c*DATA_W +: DATA_W]));
    assign acc_c = s2_c.first ? xs :
                   $signed(ram_q[c*ACC_W +: ACC_W]) + xs;
    assign acc[c*ACC_W +: ACC_W] = acc_c;
    assign shd = $signed(sum[c*ACC_W +: ACC_W]) >>> s3_c.sh;
    assign hi  = shd > MAXV;
    assign lo  = shd < MINV;
    assign sat[c] = hi | lo;
    assign satv[c*DATA_W +: DATA_W] = hi ? MAXV[DATA_W-1:0] :
                                      lo ? MINV[DATA_W-1:0] :
                                      shd[DATA_W-1:0];
  end

  // CLEAR owns the write port; the pipeline is flushed while clearing
  assign we = (state == CLEAR) || s3_v;
  assign wa = (state == CLEAR) ? clr_addr : s3_c.addr;
  assign wd = (state == CLEAR) ? '0 : sum;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    ram_q <= mem[s1_c.addr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s3_v    <= 1'b0;
      s1_c    <= '0;
      s2_c    <= '0;
      s3_c    <= '0;
      s1_x    <= '0;
      s2_x    <= '0;
      sum     <= '0;
      dout_r  <= '0;
      dv_r    <= 1'b0;
      so_r    <= 1'b0;
      sat_err <= 1'b0;
    end else begin
      s1_v <= go && inrange && !kill;
      s1_c <= c0;
      s1_x <= data_in;
      s2_v <= s1_v && !kill;
      s2_c <= s1_c;
      s2_x <= s1_x;
      s3_v <= s2_v && !kill;
      s3_c <= s2_c;
      sum  <= acc;
      if (s3_v && s3_c.last && !kill) begin
        dout_r <= satv;
        dv_r   <= 1'b1;
        so_r   <= s3_c.zero;
        if (|sat) sat_err <= 1'b1;
      end else begin
        dv_r <= 1'b0;
        so_r <= 1'b0;
      end
    end
  end

  assign data_out       = bypass ? data_in : dout_r;
  assign data_out_valid = bypass ? data_in_valid : dv_r;
  assign sync_out       = bypass ? sync : so_r;
  assign busy           = (state == CLEAR);

endmodule

// File: tb/tb_coherent_avg_multich.sv
// Directed bench for coherent_avg_multich (16-bit samples, 2 channels,
// 16 bins so the clear sweep stays short).
module tb_coherent_avg_multich;

  localparam int DW = 16;
  localparam int CH = 2;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b0;
  logic [15:0]    ptos_x_ciclo = 16'd4;
  logic [15:0]    frames_prom_coherente = 16'd1;
  logic [5:0]     shift = 6'd0;
  logic           sync = 1'b0;
  logic           bypass = 1'b0;
  logic           data_in_valid = 1'b0;
  logic [CH*DW-1:0] data_in = '0;
  logic           data_out_valid;
  logic [CH*DW-1:0] data_out;
  logic           sync_out, busy, len_err, sat_err, cfg_err;

  int passed = 0;
  int total = 0;
  int cyc = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        qs[$];
  int          qc[$];

  coherent_avg_multich #(.DATA_W(DW), .CH(CH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ptos_x_ciclo(ptos_x_ciclo),
    .frames_prom_coherente(frames_prom_coherente),
    .shift(shift), .sync(sync), .bypass(bypass),
    .data_in_valid(data_in_valid), .data_in(data_in),
    .data_out_valid(data_out_valid), .data_out(data_out),
    .sync_out(sync_out), .busy(busy), .len_err(len_err),
    .sat_err(sat_err), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_out_valid && !bypass) begin
      q0.push_back(data_out[15:0]);
      q1.push_back(data_out[31:16]);
      qs.push_back(sync_out);
      qc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int c0, input int c1, input logic s);
    tick();
    data_in = {16'(c1), 16'(c0)};
    data_in_valid = 1'b1;
    sync = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      data_in_valid = 1'b0;
      sync = 1'b0;
    end
  endtask

  task automatic clrq();
    q0.delete();
    q1.delete();
    qs.delete();
    qc.delete();
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    total++;
    if (data_out !== '0 || data_out_valid !== 1'b0 || sync_out !== 1'b0) begin
      $display("FAIL reset_outputs: got %h/%b/%b want 0/0/0",
               data_out, data_out_valid, sync_out);
    end else passed++;
    total++;
    if ({busy, len_err, sat_err, cfg_err} !== 4'b1000) begin
      $display("FAIL reset_flags: got %b want 1000",
               {busy, len_err, sat_err, cfg_err});
    end else passed++;
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n !== 16) $display("FAIL reset_clear_len: got %0d want 16", n);
    else passed++;
  endtask

  task automatic test_cfg_guard();
    clrq();
    ptos_x_ciclo = 16'd2;
    frames_prom_coherente = 16'd1;
    shift = 6'd0;
    send(5, 6, 1'b1);
    send(7, 8, 1'b0);
    send(9, 10, 1'b0);
    idle(6);
    total++;
    if (cfg_err !== 1'b1) $display("FAIL cfg_err_set: got %b want 1", cfg_err);
    else passed++;
    total++;
    if (q0.size() !== 0) $display("FAIL cfg_no_output: got %0d beats want 0", q0.size());
    else passed++;
    // N = 0 acts as N = 1: every frame is emitted
    clrq();
    ptos_x_ciclo = 16'd3;
    frames_prom_coherente = 16'd0;
    send(11, -12, 1'b1);
    send(13, -14, 1'b0);
    send(15, -16, 1'b0);
    idle(6);
    total++;
    if (q0.size() !== 3) $display("FAIL n0_count: got %0d want 3", q0.size());
    else begin
      passed++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (q0[i] !== 16'(11 + 2*i) || q1[i] !== 16'(-12 - 2*i) ||
            qs[i] !== (i == 0)) begin
          $display("FAIL n0_beat%0d: got %0d/%0d/%b want %0d/%0d/%b", i,
                   $signed(q0[i]), $signed(q1[i]), qs[i],
                   11 + 2*i, -12 - 2*i, i == 0);
        end else passed++;
      end
    end
    total++;
    if (len_err !== 1'b0) $display("FAIL n0_len_err: got %b want 0", len_err);
    else passed++;
  endtask

  task automatic test_bypass();
    tick();
    bypass = 1'b1;
    data_in = 32'h1234_ABCD;
    data_in_valid = 1'b1;
    sync = 1'b1;
    #1;
    total++;
    if (data_out !== 32'h1234_ABCD || data_out_valid !== 1'b1 || sync_out !== 1'b1) begin
      $display("FAIL bypass_on: got %h/%b/%b want 1234abcd/1/1",
               data_out, data_out_valid, sync_out);
    end else passed++;
    data_in_valid = 1'b0;
    sync = 1'b0;
    data_in = 32'h0000_5555;
    #1;
    total++;
    if (data_out !== 32'h0000_5555 || data_out_valid !== 1'b0 || sync_out !== 1'b0) begin
      $display("FAIL bypass_follow: got %h/%b/%b want 00005555/0/0",
               data_out, data_out_valid, sync_out);
    end else passed++;
    bypass = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    int t0;
    clrq();
    ptos_x_ciclo = 16'd4;
    frames_prom_coherente = 16'd4;
    shift = 6'd2;
    t0 = 0;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 4; i++) begin
        send(8, -4, i == 0);
        if (f == 3 && i == 0) t0 = cyc;
      end
    end
    idle(6);
    total++;
    if (q0.size() !== 4) $display("FAIL basic_count: got %0d want 4", q0.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q0[i] !== 16'd8 || q1[i] !== 16'hFFFC || qs[i] !== (i == 0)) begin
          $display("FAIL basic_beat%0d: got %0d/%0d/%b want 8/-4/%b", i,
                   $signed(q0[i]), $signed(q1[i]), qs[i], i == 0);
        end else passed++;
      end
      total++;
      if (qc[0] !== t0 + 4)
        $display("FAIL basic_latency: got %0d clk want 3", qc[0] - t0 - 1);
      else passed++;
    end
  endtask

  task automatic test_ramp();
    clrq();
    ptos_x_ciclo = 16'd8;
    frames_prom_coherente = 16'd16;
    shift = 6'd4;
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) idle(1);
        send(i, 100 + i, i == 0);
      end
    end
    idle(8);
    total++;
    if (q0.size() !== 8) $display("FAIL ramp_count: got %0d want 8", q0.size());
    else begin
      passed++;
      for (int i = 0; i < 8; i++) begin
        total++;
        if (q0[i] !== 16'(i) || q1[i] !== 16'(100 + i)) begin
          $display("FAIL ramp_bin%0d: got %0d/%0d want %0d/%0d", i,
                   $signed(q0[i]), $signed(q1[i]), i, 100 + i);
        end else passed++;
      end
    end
    total++;
    if (len_err !== 1'b0 || sat_err !== 1'b0)
      $display("FAIL ramp_errs: got len=%b sat=%b want 0/0", len_err, sat_err);
    else passed++;
  endtask

  task automatic test_saturation();
    clrq();
    ptos_x_ciclo = 16'd4;
    frames_prom_coherente = 16'd4;
    shift = 6'd0;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 4; i++)
        send(30000, -30000, i == 0);
    idle(6);
    total++;
    if (q0.size() !== 4) $display("FAIL sat_count: got %0d want 4", q0.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q0[i] !== 16'h7FFF || q1[i] !== 16'h8000) begin
          $display("FAIL sat_beat%0d: got %0d/%0d want 32767/-32768", i,
                   $signed(q0[i]), $signed(q1[i]));
        end else passed++;
      end
    end
    total++;
    if (sat_err !== 1'b1) $display("FAIL sat_err: got %b want 1", sat_err);
    else passed++;
  endtask

  task automatic test_overlong();
    clrq();
    ptos_x_ciclo = 16'd4;
    frames_prom_coherente = 16'd2;
    shift = 6'd1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 6; i++)
        if (i < 4) send(10 * (i + 1), -3 * (i + 1), i == 0);
        else send(999, -999, 1'b0);
    idle(6);
    total++;
    if (q0.size() !== 4) $display("FAIL long_count: got %0d want 4", q0.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q0[i] !== 16'(10 * (i + 1)) || q1[i] !== 16'(-3 * (i + 1))) begin
          $display("FAIL long_bin%0d: got %0d/%0d want %0d/%0d", i,
                   $signed(q0[i]), $signed(q1[i]), 10 * (i + 1), -3 * (i + 1));
        end else passed++;
      end
    end
    total++;
    if (len_err !== 1'b1) $display("FAIL len_err: got %b want 1", len_err);
    else passed++;
  endtask

  task automatic test_enable_midblock();
    int n;
    clrq();
    ptos_x_ciclo = 16'd4;
    frames_prom_coherente = 16'd2;
    shift = 6'd0;
    for (int i = 0; i < 4; i++) send(50, -50, i == 0);
    send(7, 7, 1'b1);
    send(8, 8, 1'b0);
    tick();
    enable = 1'b0;
    data_in_valid = 1'b0;
    sync = 1'b0;
    tick();
    total++;
    if (busy !== 1'b1) $display("FAIL en_busy_enter: got %b want 1", busy);
    else passed++;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n !== 16) $display("FAIL en_clear_len: got %0d want 16", n);
    else passed++;
    idle(4);
    total++;
    if (q0.size() !== 0) $display("FAIL en_flush: got %0d beats want 0", q0.size());
    else passed++;
    enable = 1'b1;
    idle(2);
    ptos_x_ciclo = 16'd4;
    frames_prom_coherente = 16'd2;
    shift = 6'd1;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++)
        send(6, -2, i == 0);
    idle(6);
    total++;
    if (q0.size() !== 4) $display("FAIL rerun_count: got %0d want 4", q0.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q0[i] !== 16'd6 || q1[i] !== 16'hFFFE || qs[i] !== (i == 0)) begin
          $display("FAIL rerun_beat%0d: got %0d/%0d/%b want 6/-2/%b", i,
                   $signed(q0[i]), $signed(q1[i]), qs[i], i == 0);
        end else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    total++;
    if (data_out !== 32'hFFFE_0006)
      $display("FAIL hold_value: got %h want fffe0006", data_out);
    else passed++;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (data_out !== '0 || data_out_valid !== 1'b0 || sync_out !== 1'b0) begin
      $display("FAIL async_reset_out: got %h/%b/%b want 0/0/0",
               data_out, data_out_valid, sync_out);
    end else passed++;
    total++;
    if ({busy, len_err, sat_err, cfg_err} !== 4'b1000) begin
      $display("FAIL async_reset_flags: got %b want 1000",
               {busy, len_err, sat_err, cfg_err});
    end else passed++;
    tick();
    reset_n = 1'b1;
    idle(20);
  endtask

  initial begin
    test_reset();
    test_cfg_guard();
    test_bypass();
    test_basic();
    test_ramp();
    test_saturation();
    test_overlong();
    test_enable_midblock();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
